multi_line_buffer: RTL and testbench
====================================

# multi_line_buffer

Parametrised multi-line pixel store for the sliding-window front end of the Gaussian filter pipeline. It accepts a raster pixel stream and rotates writes across `NUM_LINES` line memories. It then presents `OUT_LINES` vertically aligned pixels (one per stored line, same column) per read strobe, with a registered output and occupancy-based flow control. It replaces the single fixed 640×8 line buffer and the external rotation logic that surrounded it.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `LINE_W`, 640: pixels per line, ≥2.
- `NUM_LINES`, 4: physical line memories, ≥2.
- `OUT_LINES`, 3: lines presented per read, 1..NUM_LINES-1.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_data` in DATA_W: write pixel.
- `i_data_valid` in 1: write strobe, accepted only when `o_wr_ready`=1.
- `o_wr_ready` in/out: out 1, write acceptance.
- `i_rd_data` in 1: read strobe, honoured only when `o_rd_avail`=1.
- `o_rd_avail` out 1: ≥OUT_LINES complete unreleased lines held.
- `o_data` out OUT_LINES*DATA_W: window column; bits [DATA_W-1:0] = oldest line, top slice = newest.
- `o_data_valid` out 1: `o_data` valid this cycle.
- `o_line_done` out 1: one-cycle pulse coincident with `o_data_valid` of column LINE_W-1.
- `o_ovf` out 1: sticky write-overflow flag (see Configuration).

## Operation
- Write column counter `wr_col` (0..LINE_W-1) and write line index `wr_line` (0..NUM_LINES-1), both wrap to 0.
- On an accepted write, `line[wr_line][wr_col]` is loaded. At `wr_col`=LINE_W-1 the line completes: `wr_col`→0, `wr_line`→next, `filled`+1.
- `filled`: count of complete, unreleased lines, range 0..NUM_LINES, width clog2(NUM_LINES+1).
- `o_wr_ready` = (`filled` < NUM_LINES). The line under write never overlaps an unreleased line.
- `o_rd_avail` = (`filled` ≥ OUT_LINES).
- Read state: `rd_col` (0..LINE_W-1) and `rd_base` (index of oldest unreleased line).
  - An honoured read fetches column `rd_col` from lines `rd_base .. rd_base+OUT_LINES-1`, modulo NUM_LINES.
  - At `rd_col`=LINE_W-1: `rd_col`→0, `rd_base`→next, `filled`−1. Only one line is released per read row, so windows slide vertically by one.
- Simultaneous line completion (write) and line release (read) in the same cycle leave `filled` unchanged.
- `i_rd_data` while `o_rd_avail`=0 is ignored: no pointer change, no `o_data_valid`.
- `i_data_valid` while `o_wr_ready`=0 is dropped: no pointer or memory change.

## Timing
- Read latency is 1 cycle. A strobe at edge N gives `o_data`/`o_data_valid` after edge N+1. Back-to-back strobes give one column per cycle.
- `o_data` holds its last value when `o_data_valid`=0.
- A write to column c of a line and a read of the same location cannot coincide, because read lines are always complete.
- `o_wr_ready` and `o_rd_avail` are combinational from `filled`. They update the cycle after the completing or releasing edge.
- Reset values (asynchronous, immediate): `wr_col`, `wr_line`, `rd_col`, `rd_base`, `filled`, `o_data`, `o_data_valid`, `o_line_done`, `o_ovf` = 0. After reset `o_wr_ready`=1 and `o_rd_avail`=0.
- Reset mid-line discards all partial and complete lines. Memory contents are not cleared and are unobservable until rewritten.

## Configuration
- `LINEBUF_OVF_FLAG_EN` defined: `o_ovf` sets on any cycle with `i_data_valid`=1 and `o_wr_ready`=0, and stays set until reset.
- Not defined: `o_ovf` is tied 0 and no detection logic is built. Port list is unchanged.

## Structure
- Shared package `linebuf_pkg` holds:
  - the clog2 helper function;
  - the default constants `LINEBUF_DATA_W`=8 and `LINEBUF_LINE_W`=640.
- Sub-module `line_ram`: one simple dual-port line memory (DATA_W × LINE_W) with synchronous write port and registered read port. It is instantiated NUM_LINES times via generate.
- Top level holds the counters, the `filled` tracker, the read-select rotation (output slice k ← `line_ram[(rd_base+k) mod NUM_LINES]`, with `rd_base` registered alongside the read) and the flag logic.

## Test plan
Configuration for all scenarios: DATA_W=8, LINE_W=8, NUM_LINES=4, OUT_LINES=3.
- Write lines 0,1,2 (pixel value = line*16+col) → `o_rd_avail` rises the cycle after pixel 23 is written. 8 reads return 0x201000..0x271707 with 1-cycle latency, and `o_line_done` accompanies 0x271707.
- Write 32 pixels without reading → `o_wr_ready`=0 after 32nd write; a 33rd write is dropped. With `LINEBUF_OVF_FLAG_EN`, `o_ovf`=1 and stays 1.
- Continuous stream of 6 lines, reading whenever available → read rows return line sets {0,1,2},{1,2,3},{2,3,4},{3,4,5}. Slice order is correct across the `rd_base` wrap 3→0.
- Force write line completion and read release on the same edge → `filled` stays 3 and `o_rd_avail` stays 1.
- Read strobes with `filled`=2 → no `o_data_valid`, `rd_col` stays 0.
- Assert `i_rst_n`=0 mid-read after 5 columns → `o_data_valid`, `o_rd_avail` drop immediately. After release `o_wr_ready`=1, and the next 24 writes plus 8 reads return the new data from column 0.

Source files
------------

// File: rtl/linebuf_pkg.sv
// linebuf_pkg
//   Shared definitions for the multi-line pixel buffer.
//   Contents:
//     LINEBUF_DATA_W - default pixel width in bits
//     LINEBUF_LINE_W - default pixels per line
//     clog2()        - ceiling log2, never less than 1, so that a one-entry
//                      range still gets a usable one-bit counter
package linebuf_pkg;

  localparam int LINEBUF_DATA_W = 8;
  localparam int LINEBUF_LINE_W = 640;

  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram
//   One line of pixel storage. It is a simple dual-port memory with a
//   synchronous write port and a registered read port. The read register
//   holds its value whenever no read is requested. It is reset to zero, so
//   the buffer output reads as zero straight after reset.
//   Ports:
//     i_clk     - clock, rising edge
//     i_rst_n   - asynchronous active-low reset (read register only)
//     i_wr_en   - write strobe
//     i_wr_addr - write column
//     i_wr_data - write pixel
//     i_rd_en   - read strobe; loads the read register
//     i_rd_addr - read column
//     o_rd_data - registered read pixel
module line_ram
  import linebuf_pkg::*;
#(
  parameter int DATA_W = LINEBUF_DATA_W,
  parameter int LINE_W = LINEBUF_LINE_W,
  parameter int ADDR_W = clog2(LINE_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] mem [LINE_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // The storage array has no reset so that it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) begin
      rd_data_d = mem[i_rd_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/multi_line_buffer.sv
// multi_line_buffer
//   Multi-line pixel store for the sliding-window front end. Raster writes
//   rotate across NUM_LINES line memories. Each honoured read strobe
//   returns one column from OUT_LINES consecutive complete lines, one cycle
//   later. Each completed read row releases only the oldest line, so the
//   window slides down by one line per row.
//   Optional feature:
//     LINEBUF_OVF_FLAG_EN - when defined, o_ovf is a sticky flag. It is set
//                           by any write strobe presented while the buffer
//                           is full. When undefined, o_ovf is tied low.
//   Ports:
//     i_clk        - clock, rising edge
//     i_rst_n      - asynchronous active-low reset
//     i_data       - write pixel
//     i_data_valid - write strobe (accepted when o_wr_ready=1)
//     o_wr_ready   - a line slot is free for writing
//     i_rd_data    - read strobe (honoured when o_rd_avail=1)
//     o_rd_avail   - at least OUT_LINES complete unreleased lines are held
//     o_data       - window column, oldest line in the low slice
//     o_data_valid - o_data was produced by a read this cycle
//     o_line_done  - last column of a read row is on o_data
//     o_ovf        - sticky write-overflow flag
module multi_line_buffer
  import linebuf_pkg::*;
#(
  parameter int DATA_W    = LINEBUF_DATA_W,
  parameter int LINE_W    = LINEBUF_LINE_W,
  parameter int NUM_LINES = 4,
  parameter int OUT_LINES = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_data_valid,
  output logic                        o_wr_ready,
  input  logic                        i_rd_data,
  output logic                        o_rd_avail,
  output logic [OUT_LINES*DATA_W-1:0] o_data,
  output logic                        o_data_valid,
  output logic                        o_line_done,
  output logic                        o_ovf
);

  localparam int COL_W  = clog2(LINE_W);
  localparam int IDX_W  = clog2(NUM_LINES);
  localparam int FILL_W = clog2(NUM_LINES + 1);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LINES - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_LINES);
  localparam logic [FILL_W-1:0] FILL_READ = FILL_W'(OUT_LINES);

  logic [COL_W-1:0]  wr_col_q,   wr_col_d;
  logic [IDX_W-1:0]  wr_line_q,  wr_line_d;
  logic [COL_W-1:0]  rd_col_q,   rd_col_d;
  logic [IDX_W-1:0]  rd_base_q,  rd_base_d;
  logic [IDX_W-1:0]  sel_base_q, sel_base_d;
  logic [FILL_W-1:0] filled_q,   filled_d;
  logic              data_valid_q, data_valid_d;
  logic              line_done_q,  line_done_d;

  logic wr_fire;
  logic rd_fire;
  logic wr_line_end;
  logic rd_line_end;

  logic [DATA_W-1:0] ram_rd_data [NUM_LINES];

  // Flow control depends only on the count of complete, unreleased lines.
  // A new line may be written only into a slot that holds no unreleased
  // data.
  assign o_wr_ready = (filled_q < FILL_FULL);
  assign o_rd_avail = (filled_q >= FILL_READ);

  always_comb begin
    wr_fire     = i_data_valid & o_wr_ready;
    rd_fire     = i_rd_data & o_rd_avail;
    wr_line_end = wr_fire & (wr_col_q == LAST_COL);
    rd_line_end = rd_fire & (rd_col_q == LAST_COL);
  end

  // Write side: the column advances on every accepted pixel. The line
  // index rotates when a line completes.
  always_comb begin
    wr_col_d  = wr_col_q;
    wr_line_d = wr_line_q;
    if (wr_fire) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_line_d = (wr_line_q == LAST_IDX) ? '0 : wr_line_q + IDX_W'(1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
  end

  // Read side: the column advances on every honoured strobe. Finishing a
  // row releases the oldest line. sel_base captures the base used for this
  // read, so the output rotation stays matched to the RAM read registers.
  always_comb begin
    rd_col_d     = rd_col_q;
    rd_base_d    = rd_base_q;
    sel_base_d   = sel_base_q;
    data_valid_d = rd_fire;
    line_done_d  = rd_line_end;
    if (rd_fire) begin
      sel_base_d = rd_base_q;
      if (rd_col_q == LAST_COL) begin
        rd_col_d  = '0;
        rd_base_d = (rd_base_q == LAST_IDX) ? '0 : rd_base_q + IDX_W'(1);
      end else begin
        rd_col_d = rd_col_q + COL_W'(1);
      end
    end
  end

  // A line completing and a line being released on the same edge cancel
  // each other, so filled is unchanged.
  always_comb begin
    filled_d = filled_q;
    case ({wr_line_end, rd_line_end})
      2'b10:   filled_d = filled_q + FILL_W'(1);
      2'b01:   filled_d = filled_q - FILL_W'(1);
      default: filled_d = filled_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_col_q     <= '0;
      wr_line_q    <= '0;
      rd_col_q     <= '0;
      rd_base_q    <= '0;
      sel_base_q   <= '0;
      filled_q     <= '0;
      data_valid_q <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      wr_col_q     <= wr_col_d;
      wr_line_q    <= wr_line_d;
      rd_col_q     <= rd_col_d;
      rd_base_q    <= rd_base_d;
      sel_base_q   <= sel_base_d;
      filled_q     <= filled_d;
      data_valid_q <= data_valid_d;
      line_done_q  <= line_done_d;
    end
  end

  // Every line memory reads the same column on an honoured strobe. The
  // rotation below picks which of them make up the window.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    line_ram #(
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .ADDR_W (COL_W)
    ) u_line_ram (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (wr_fire && (wr_line_q == IDX_W'(g))),
      .i_wr_addr (wr_col_q),
      .i_wr_data (i_data),
      .i_rd_en   (rd_fire),
      .i_rd_addr (rd_col_q),
      .o_rd_data (ram_rd_data[g])
    );
  end

  // Output slice k comes from line (sel_base + k) mod NUM_LINES. The
  // subtraction wraps the index without a divider for any NUM_LINES. Both
  // the RAM read registers and sel_base hold between reads, so o_data
  // holds as well.
  always_comb begin
    int sel;
    o_data = '0;
    for (int k = 0; k < OUT_LINES; k++) begin
      sel = int'(sel_base_q) + k;
      if (sel >= NUM_LINES) begin
        sel = sel - NUM_LINES;
      end
      o_data[k*DATA_W +: DATA_W] = ram_rd_data[sel];
    end
  end

  assign o_data_valid = data_valid_q;
  assign o_line_done  = line_done_q;

`ifdef LINEBUF_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Sticky until reset: any write attempt while full is recorded.
  always_comb begin
    ovf_d = ovf_q | (i_data_valid & ~o_wr_ready);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multi_line_buffer.sv
// tb_multi_line_buffer
//   Self-checking bench for multi_line_buffer with DATA_W=8, LINE_W=8,
//   NUM_LINES=4, OUT_LINES=3. The reference model keeps the complete lines
//   as a flat pixel queue with the oldest line first, plus the partial line
//   under write. Availability, readiness and the expected window column are
//   derived from the queue contents.
module tb_multi_line_buffer;

  localparam int DATA_W    = 8;
  localparam int LINE_W    = 8;
  localparam int NUM_LINES = 4;
  localparam int OUT_LINES = 3;
  localparam int OUT_W     = OUT_LINES * DATA_W;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_data_valid = 1'b0;
  logic              o_wr_ready;
  logic              i_rd_data = 1'b0;
  logic              o_rd_avail;
  logic [OUT_W-1:0]  o_data;
  logic              o_data_valid;
  logic              o_line_done;
  logic              o_ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] done_px[$];
  logic [DATA_W-1:0] cur_px[$];
  int                m_rd_col;
  bit                m_ovf;
  logic [OUT_W-1:0]  exp_data;
  bit                exp_valid;
  bit                exp_done;

  always #5 i_clk = ~i_clk;

  multi_line_buffer #(
    .DATA_W    (DATA_W),
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES),
    .OUT_LINES (OUT_LINES)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_wr_ready   (o_wr_ready),
    .i_rd_data    (i_rd_data),
    .o_rd_avail   (o_rd_avail),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_line_done  (o_line_done),
    .o_ovf        (o_ovf)
  );

  function automatic bit m_ready();
    return (done_px.size() / LINE_W) < NUM_LINES;
  endfunction

  function automatic bit m_avail();
    return (done_px.size() / LINE_W) >= OUT_LINES;
  endfunction

  function automatic bit exp_ovf();
`ifdef LINEBUF_OVF_FLAG_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    done_px.delete();
    cur_px.delete();
    m_rd_col  = 0;
    m_ovf     = 1'b0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model from its pre-edge state,
  // and return 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit wr_acc;
    bit rd_acc;
    i_data_valid = v;
    i_data       = d;
    i_rd_data    = r;
    wr_acc = v && m_ready();
    rd_acc = r && m_avail();
    if (v && !m_ready()) m_ovf = 1'b1;
    exp_valid = rd_acc;
    exp_done  = rd_acc && (m_rd_col == LINE_W - 1);
    if (rd_acc) begin
      for (int k = 0; k < OUT_LINES; k++) begin
        exp_data[k*DATA_W +: DATA_W] = done_px[k*LINE_W + m_rd_col];
      end
      if (m_rd_col == LINE_W - 1) begin
        for (int i = 0; i < LINE_W; i++) void'(done_px.pop_front());
        m_rd_col = 0;
      end else begin
        m_rd_col++;
      end
    end
    if (wr_acc) begin
      cur_px.push_back(d);
      if (cur_px.size() == LINE_W) begin
        foreach (cur_px[i]) done_px.push_back(cur_px[i]);
        cur_px.delete();
      end
    end
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
  endtask

  task automatic do_reset();
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    i_rst_n      = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (o_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset.wr_ready: got %b want 1", o_wr_ready); end
    n_vec++; if (o_rd_avail !== 1'b0) begin n_err++; $display("[TB] FAIL reset.rd_avail: got %b want 0", o_rd_avail); end
    n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset.data_valid: got %b want 0", o_data_valid); end
    n_vec++; if (o_line_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset.line_done: got %b want 0", o_line_done); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("[TB] FAIL reset.data: got %h want 0", o_data); end
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("[TB] FAIL reset.ovf: got %b want 0", o_ovf); end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_basic();
    do_reset();
    for (int p = 0; p < 3 * LINE_W; p++) begin
      step(1'b1, DATA_W'((p / LINE_W) * 16 + (p % LINE_W)), 1'b0);
      n_vec++; if (o_rd_avail !== m_avail()) begin n_err++; $display("[TB] FAIL basic.rd_avail px%0d: got %b want %b", p, o_rd_avail, m_avail()); end
      n_vec++; if (o_wr_ready !== m_ready()) begin n_err++; $display("[TB] FAIL basic.wr_ready px%0d: got %b want %b", p, o_wr_ready, m_ready()); end
    end
    for (int c = 0; c < LINE_W; c++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (o_data_valid !== exp_valid) begin n_err++; $display("[TB] FAIL basic.valid col%0d: got %b want %b", c, o_data_valid, exp_valid); end
      n_vec++; if (o_data !== exp_data) begin n_err++; $display("[TB] FAIL basic.data col%0d: got %h want %h", c, o_data, exp_data); end
      n_vec++; if (o_line_done !== exp_done) begin n_err++; $display("[TB] FAIL basic.line_done col%0d: got %b want %b", c, o_line_done, exp_done); end
    end
    n_vec++; if (o_data !== 24'h271707) begin n_err++; $display("[TB] FAIL basic.last_col: got %h want 271707", o_data); end
    step(1'b0, '0, 1'b0);
    n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic.idle_valid: got %b want 0", o_data_valid); end
    n_vec++; if (o_data !== 24'h271707) begin n_err++; $display("[TB] FAIL basic.hold: got %h want 271707", o_data); end
    n_vec++; if (o_rd_avail !== 1'b0) begin n_err++; $display("[TB] FAIL basic.after_release_avail: got %b want 0", o_rd_avail); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int p = 0; p < NUM_LINES * LINE_W; p++) begin
      step(1'b1, DATA_W'($urandom), 1'b0);
    end
    n_vec++; if (o_wr_ready !== 1'b0) begin n_err++; $display("[TB] FAIL ovf.wr_ready_full: got %b want 0", o_wr_ready); end
    step(1'b1, DATA_W'($urandom), 1'b0);
    n_vec++; if (o_ovf !== exp_ovf()) begin n_err++; $display("[TB] FAIL ovf.flag: got %b want %b", o_ovf, exp_ovf()); end
    step(1'b0, '0, 1'b0);
    n_vec++; if (o_ovf !== exp_ovf()) begin n_err++; $display("[TB] FAIL ovf.sticky: got %b want %b", o_ovf, exp_ovf()); end
    for (int c = 0; c < LINE_W; c++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (o_data !== exp_data || o_data_valid !== exp_valid) begin n_err++; $display("[TB] FAIL ovf.row0 col%0d: got %h/%b want %h/%b", c, o_data, o_data_valid, exp_data, exp_valid); end
    end
    n_vec++; if (o_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL ovf.wr_ready_freed: got %b want 1", o_wr_ready); end
    n_vec++; if (o_ovf !== exp_ovf()) begin n_err++; $display("[TB] FAIL ovf.sticky2: got %b want %b", o_ovf, exp_ovf()); end
  endtask

  task automatic test_stream();
    int written;
    int rows;
    int cyc;
    do_reset();
    written = 0;
    rows    = 0;
    cyc     = 0;
    while (written < 6 * LINE_W || m_avail()) begin
      bit v;
      v = (written < 6 * LINE_W) && m_ready();
      step(v, DATA_W'($urandom), m_avail());
      if (v) written++;
      if (o_line_done === 1'b1) rows++;
      n_vec++; if (o_data_valid !== exp_valid || o_data !== exp_data || o_line_done !== exp_done) begin n_err++; $display("[TB] FAIL stream.out cyc%0d: got %h/%b/%b want %h/%b/%b", cyc, o_data, o_data_valid, o_line_done, exp_data, exp_valid, exp_done); end
      n_vec++; if (o_rd_avail !== m_avail() || o_wr_ready !== m_ready()) begin n_err++; $display("[TB] FAIL stream.flags cyc%0d: got %b%b want %b%b", cyc, o_rd_avail, o_wr_ready, m_avail(), m_ready()); end
      cyc++;
      if (cyc > 400) begin
        n_vec++; n_err++;
        $display("[TB] FAIL stream.timeout: got %0d cycles want <= 400", cyc);
        break;
      end
    end
    n_vec++; if (rows !== 4) begin n_err++; $display("[TB] FAIL stream.rows: got %0d want 4", rows); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int p = 0; p < 3 * LINE_W; p++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int c = 0; c < LINE_W; c++) begin
      step(1'b1, DATA_W'($urandom), 1'b1);
      n_vec++; if (o_data !== exp_data || o_data_valid !== exp_valid || o_line_done !== exp_done) begin n_err++; $display("[TB] FAIL simul.out col%0d: got %h/%b/%b want %h/%b/%b", c, o_data, o_data_valid, o_line_done, exp_data, exp_valid, exp_done); end
    end
    n_vec++; if (o_rd_avail !== 1'b1) begin n_err++; $display("[TB] FAIL simul.rd_avail: got %b want 1", o_rd_avail); end
    n_vec++; if (o_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL simul.wr_ready: got %b want 1", o_wr_ready); end
    step(1'b0, '0, 1'b1);
    n_vec++; if (o_data !== exp_data || o_data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL simul.next_row: got %h/%b want %h/1", o_data, o_data_valid, exp_data); end
  endtask

  task automatic test_no_avail();
    do_reset();
    for (int p = 0; p < 2 * LINE_W; p++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL noavail.valid try%0d: got %b want 0", i, o_data_valid); end
    end
    for (int p = 0; p < LINE_W; p++) step(1'b1, DATA_W'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    n_vec++; if (o_data !== exp_data || o_data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL noavail.col0: got %h/%b want %h/1", o_data, o_data_valid, exp_data); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int p = 0; p < 3 * LINE_W; p++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1);
    n_vec++; if (o_data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midrst.pre_valid: got %b want 1", o_data_valid); end
    i_rd_data = 1'b1;
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst.valid: got %b want 0", o_data_valid); end
    n_vec++; if (o_rd_avail !== 1'b0) begin n_err++; $display("[TB] FAIL midrst.rd_avail: got %b want 0", o_rd_avail); end
    i_rd_data = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    n_vec++; if (o_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midrst.wr_ready: got %b want 1", o_wr_ready); end
    for (int p = 0; p < 3 * LINE_W; p++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int c = 0; c < LINE_W; c++) begin
      step(1'b0, '0, 1'b1);
      n_vec++; if (o_data !== exp_data || o_data_valid !== exp_valid || o_line_done !== exp_done) begin n_err++; $display("[TB] FAIL midrst.out col%0d: got %h/%b/%b want %h/%b/%b", c, o_data, o_data_valid, o_line_done, exp_data, exp_valid, exp_done); end
    end
  endtask

  initial begin
    $display("[TB] multi_line_buffer bench start");
    test_reset();
    test_basic();
    test_overflow();
    test_stream();
    test_simultaneous();
    test_no_avail();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
